// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing a 4-bit HD44780 bus between two byte requesters; each byte goes out as two timed nibbles.
// Latency: the nibble sequence starts the cycle after acceptance; the bus is busy for 2*SETUP+2*EN_HIGH+GAP+wait cycles.
// Backpressure: reqN_ready asserts only in IDLE. Define LCD_INIT_SEQ_EN to run the power-up init sequence after reset.
module lcd_bus_arbiter #(
    parameter int SETUP_CYC     = 5,
    parameter int EN_HIGH_CYC   = 50,
    parameter int GAP_CYC       = 100,
    parameter int CMD_WAIT_CYC  = 4_000,
    parameter int LONG_WAIT_CYC = 160_000,
    parameter int POWERUP_CYC   = 1_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       last_grant,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [3:0] LCD_DATA
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(GAP_CYC, CMD_WAIT_CYC)),
                               max2(LONG_WAIT_CYC, POWERUP_CYC));
    localparam int CW   = $clog2(MAXP + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t ONE     = cnt_t'(1);
    localparam cnt_t L_SETUP = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t L_EN    = cnt_t'(EN_HIGH_CYC - 1);
    localparam cnt_t L_GAP   = cnt_t'(GAP_CYC - 1);
    localparam cnt_t L_CMD   = cnt_t'(CMD_WAIT_CYC - 1);
    localparam cnt_t L_LONG  = cnt_t'(LONG_WAIT_CYC - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP_H,
        ST_EN_H,
        ST_GAP,
        ST_SETUP_L,
        ST_EN_L,
        ST_WAIT,
        ST_PWRUP,
        ST_INIT_SETUP,
        ST_INIT_EN,
        ST_INIT_WAIT
    } state_t;

    state_t     state, next_state;
    cnt_t       cnt, cnt_nxt;
    logic       rs_q;
    logic [7:0] byte_q;
    logic       last_grant_q;
    logic       lcd_rs_q, lcd_en_q;
    logic [3:0] lcd_data_q;

    logic       idle, timeout, long_cmd;
    logic       rdy0, rdy1;
    logic       load_byte, ld_rs, ld_low, en_nxt;
    logic [7:0] ld_byte;
    logic       upd_grant, new_grant;
    cnt_t       wait_len;

`ifdef LCD_INIT_SEQ_EN
    logic       init_act;
    logic [2:0] init_idx;
    logic       ld_nib, init_adv, init_end;
    logic [3:0] nib_val;

    // Steps 0..3 are single nibbles, steps 4..7 are full bytes through the normal path.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd4:    return 8'h28;
            3'd5:    return 8'h0C;
            3'd6:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [3:0] init_nib(input logic [2:0] idx);
        return (idx == 3'd3) ? 4'h2 : 4'h3;
    endfunction
`endif

    assign idle     = (state == ST_IDLE);
    assign timeout  = (cnt == '0);
    assign rdy0     = idle & req0_valid & (~req1_valid | last_grant_q);
    assign rdy1     = idle & req1_valid & (~req0_valid | ~last_grant_q);
    // Clear and home need the long controller execution time.
    assign long_cmd = ~rs_q & ((byte_q == 8'h01) | (byte_q == 8'h02) | (byte_q == 8'h03));
    assign wait_len = long_cmd ? L_LONG : L_CMD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef LCD_INIT_SEQ_EN
            state <= ST_PWRUP;
`else
            state <= ST_IDLE;
`endif
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        load_byte  = 1'b0;
        ld_rs      = 1'b0;
        ld_byte    = 8'h00;
        ld_low     = 1'b0;
        upd_grant  = 1'b0;
        new_grant  = last_grant_q;
`ifdef LCD_INIT_SEQ_EN
        ld_nib     = 1'b0;
        nib_val    = 4'h0;
        init_adv   = 1'b0;
        init_end   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (rdy0) begin
                    load_byte  = 1'b1;
                    ld_rs      = req0_rs;
                    ld_byte    = req0_data;
                    upd_grant  = 1'b1;
                    new_grant  = 1'b0;
                    next_state = ST_SETUP_H;
                    cnt_nxt    = L_SETUP;
                end else if (rdy1) begin
                    load_byte  = 1'b1;
                    ld_rs      = req1_rs;
                    ld_byte    = req1_data;
                    upd_grant  = 1'b1;
                    new_grant  = 1'b1;
                    next_state = ST_SETUP_H;
                    cnt_nxt    = L_SETUP;
                end
            end
            ST_SETUP_H: begin
                if (timeout) begin
                    next_state = ST_EN_H;
                    cnt_nxt    = L_EN;
                end else cnt_nxt = cnt - ONE;
            end
            ST_EN_H: begin
                if (timeout) begin
                    next_state = ST_GAP;
                    cnt_nxt    = L_GAP;
                end else cnt_nxt = cnt - ONE;
            end
            ST_GAP: begin
                if (timeout) begin
                    next_state = ST_SETUP_L;
                    cnt_nxt    = L_SETUP;
                    ld_low     = 1'b1;
                end else cnt_nxt = cnt - ONE;
            end
            ST_SETUP_L: begin
                if (timeout) begin
                    next_state = ST_EN_L;
                    cnt_nxt    = L_EN;
                end else cnt_nxt = cnt - ONE;
            end
            ST_EN_L: begin
                if (timeout) begin
                    next_state = ST_WAIT;
                    cnt_nxt    = wait_len;
                end else cnt_nxt = cnt - ONE;
            end
            ST_WAIT: begin
                if (timeout) begin
                    next_state = ST_IDLE;
                    cnt_nxt    = '0;
`ifdef LCD_INIT_SEQ_EN
                    if (init_act) begin
                        if (init_idx == 3'd7) begin
                            init_end = 1'b1;
                        end else begin
                            init_adv   = 1'b1;
                            load_byte  = 1'b1;
                            ld_byte    = init_cmd(init_idx + 3'd1);
                            next_state = ST_SETUP_H;
                            cnt_nxt    = L_SETUP;
                        end
                    end
`endif
                end else cnt_nxt = cnt - ONE;
            end
`ifdef LCD_INIT_SEQ_EN
            ST_PWRUP: begin
                if (timeout) begin
                    ld_nib     = 1'b1;
                    nib_val    = init_nib(init_idx);
                    next_state = ST_INIT_SETUP;
                    cnt_nxt    = L_SETUP;
                end else cnt_nxt = cnt - ONE;
            end
            ST_INIT_SETUP: begin
                if (timeout) begin
                    next_state = ST_INIT_EN;
                    cnt_nxt    = L_EN;
                end else cnt_nxt = cnt - ONE;
            end
            ST_INIT_EN: begin
                if (timeout) begin
                    next_state = ST_INIT_WAIT;
                    cnt_nxt    = L_LONG;
                end else cnt_nxt = cnt - ONE;
            end
            ST_INIT_WAIT: begin
                if (timeout) begin
                    init_adv = 1'b1;
                    if (init_idx == 3'd3) begin
                        load_byte  = 1'b1;
                        ld_byte    = init_cmd(3'd4);
                        next_state = ST_SETUP_H;
                    end else begin
                        ld_nib     = 1'b1;
                        nib_val    = init_nib(init_idx + 3'd1);
                        next_state = ST_INIT_SETUP;
                    end
                    cnt_nxt = L_SETUP;
                end else cnt_nxt = cnt - ONE;
            end
`endif
            default: begin
                next_state = ST_IDLE;
                cnt_nxt    = '0;
            end
        endcase
        en_nxt = (next_state == ST_EN_H) | (next_state == ST_EN_L) | (next_state == ST_INIT_EN);
    end

    // EN is registered from next_state so the pin is glitch-free and aligned with the EN states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef LCD_INIT_SEQ_EN
            cnt      <= cnt_t'(POWERUP_CYC - 1);
            init_act <= 1'b1;
            init_idx <= 3'd0;
`else
            cnt      <= '0;
`endif
            rs_q         <= 1'b0;
            byte_q       <= 8'h00;
            last_grant_q <= 1'b1;
            lcd_rs_q     <= 1'b0;
            lcd_en_q     <= 1'b0;
            lcd_data_q   <= 4'h0;
        end else begin
            cnt      <= cnt_nxt;
            lcd_en_q <= en_nxt;
            if (load_byte) begin
                rs_q       <= ld_rs;
                byte_q     <= ld_byte;
                lcd_rs_q   <= ld_rs;
                lcd_data_q <= ld_byte[7:4];
            end
            if (ld_low)
                lcd_data_q <= byte_q[3:0];
            if (upd_grant)
                last_grant_q <= new_grant;
`ifdef LCD_INIT_SEQ_EN
            if (ld_nib) begin
                lcd_rs_q   <= 1'b0;
                lcd_data_q <= nib_val;
            end
            if (init_adv)
                init_idx <= init_idx + 3'd1;
            if (init_end)
                init_act <= 1'b0;
`endif
        end
    end

    assign req0_ready = rdy0;
    assign req1_ready = rdy1;
    assign busy       = ~idle;
    assign last_grant = last_grant_q;
    assign LCD_RS     = lcd_rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = lcd_en_q;
    assign LCD_DATA   = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: expected nibbles are queued at acceptance and popped on each LCD_EN rise.
module tb_lcd_bus_arbiter;

    localparam int SU = 2;
    localparam int EH = 4;
    localparam int GP = 3;
    localparam int CWT = 10;
    localparam int LW = 40;
    localparam int PU = 20;
    localparam int SHORT_BUSY = 2*SU + 2*EH + GP + CWT;
    localparam int LONG_BUSY  = 2*SU + 2*EH + GP + LW;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_ready;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_ready;
    logic [7:0] req1_data = 8'h00;
    logic       busy, last_grant, LCD_RS, LCD_RW, LCD_EN;
    logic [3:0] LCD_DATA;

    lcd_bus_arbiter #(
        .SETUP_CYC(SU), .EN_HIGH_CYC(EH), .GAP_CYC(GP),
        .CMD_WAIT_CYC(CWT), .LONG_WAIT_CYC(LW), .POWERUP_CYC(PU)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .busy(busy), .last_grant(last_grant),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
    );

    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs != exp) begin
            miss_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_byte(input logic rs, input logic [7:0] d);
        exp_q.push_back({rs, d[7:4]});
        exp_q.push_back({rs, d[3:0]});
    endfunction

    // Bus monitor: nibble content on EN rise, stability while EN high, EN pulse width on fall.
    logic       en_prev = 1'b0;
    int         hi_cnt  = 0;
    int         en_rises = 0;
    logic [4:0] snap = 5'h0;
    bit         abort = 1'b0;

    always @(negedge clk) begin
        if (LCD_EN) begin
            if (!en_prev) begin
                en_rises++;
                hi_cnt = 1;
                snap = {LCD_RS, LCD_DATA};
                if (exp_q.size() == 0) check("unexpected_nibble", 1, 0);
                else check("nibble", snap, exp_q.pop_front());
            end else begin
                hi_cnt++;
                check("hold_during_en", {LCD_RS, LCD_DATA}, snap);
            end
        end else if (en_prev) begin
            if (abort) abort = 1'b0;
            else check("en_high_len", hi_cnt, EH);
        end
        en_prev = LCD_EN;
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
`ifdef LCD_INIT_SEQ_EN
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h01);
        #1;
        check("init_busy", busy, 1);
        @(negedge clk);
        wait_idle(3000);
        check("init_queue_drained", exp_q.size(), 0);
`endif
    endtask

    // Called at a negedge; returns at a negedge once the DUT is idle again.
    task automatic send(input int p, input logic rs, input logic [7:0] d, output int blen);
        int n = 0;
        blen = 0;
        if (p == 0) begin req0_rs = rs; req0_data = d; req0_valid = 1'b1; end
        else        begin req1_rs = rs; req1_data = d; req1_valid = 1'b1; end
        #1;
        while (!(p == 0 ? req0_ready : req1_ready) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            check("ready_timeout", 0, 1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        push_byte(rs, d);
        @(posedge clk); #1;
        check("ready_one_cycle", p == 0 ? req0_ready : req1_ready, 0);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        while (busy && blen < 1000) begin
            blen++;
            @(posedge clk); #1;
        end
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
        $fatal(1);
    end

    initial begin
        int blen, n, viol, both, who, cyc, start;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_lcd_en", LCD_EN, 0);
        check("rst_lcd_rs", LCD_RS, 0);
        check("rst_lcd_rw", LCD_RW, 0);
        check("rst_lcd_data", LCD_DATA, 0);
        check("rst_last_grant", last_grant, 1);
`ifdef LCD_INIT_SEQ_EN
        check("rst_busy", busy, 1);
`else
        check("rst_busy", busy, 0);
`endif
        do_reset();

        // Single data byte from requester 0
        send(0, 1'b1, 8'h48, blen);
        check("busy_len_48", blen, SHORT_BUSY);
        check("last_grant_s1", last_grant, 0);
        check("idle_hold_rs", LCD_RS, 1);
        check("idle_hold_data", LCD_DATA, 4'h8);

        // Both requesters valid continuously after reset
        do_reset();
        req0_rs = 1'b1; req0_data = 8'h41; req1_rs = 1'b1; req1_data = 8'h42;
        req0_valid = 1'b1; req1_valid = 1'b1;
        both = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 500) begin
                @(negedge clk); #1;
                if (req0_ready && req1_ready) both++;
                n++;
            end
            if (req0_ready && req1_ready) both++;
            who = req1_ready ? 1 : 0;
            check("rr_order", who, k % 2);
            push_byte(1'b1, who == 1 ? 8'h42 : 8'h41);
            @(posedge clk); #1;
            check("rr_last_grant", last_grant, k % 2);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("rr_both_ready", both, 0);
        wait_idle(1000);

        // Wait length selection: long only for RS=0 clear/home
        send(1, 1'b0, 8'h01, blen); check("busy_clear", blen, LONG_BUSY);
        send(1, 1'b1, 8'h01, blen); check("busy_data01", blen, SHORT_BUSY);
        send(1, 1'b0, 8'h02, blen); check("busy_home02", blen, LONG_BUSY);
        send(1, 1'b0, 8'h03, blen); check("busy_home03", blen, LONG_BUSY);
        send(1, 1'b0, 8'h04, blen); check("busy_cmd04", blen, SHORT_BUSY);
        send(0, 1'b0, 8'h00, blen); check("busy_cmd00", blen, SHORT_BUSY);

        // Valid held during busy, data changed before acceptance
        req0_rs = 1'b1; req0_data = 8'h33; req0_valid = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 500) begin @(negedge clk); #1; n++; end
        check("s5_first_ready", req0_ready, 1);
        push_byte(1'b1, 8'h33);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_rs = 1'b1; req1_data = 8'h11; req1_valid = 1'b1;
        viol = 0; cyc = 0;
        while (busy && cyc < 1000) begin
            if (req1_ready) viol++;
            if (cyc == 10) req1_data = 8'h5A;
            cyc++;
            @(posedge clk); #1;
        end
        check("ready_while_busy", viol, 0);
        check("busy_len_s5", cyc, SHORT_BUSY);
        check("ready_after_idle", req1_ready, 1);
        @(negedge clk);
        send(1, 1'b1, 8'h5A, blen);
        check("busy_len_5a", blen, SHORT_BUSY);

        // Reset during the low-nibble EN pulse
        start = en_rises;
        req0_rs = 1'b1; req0_data = 8'hA5; req0_valid = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 500) begin @(negedge clk); #1; n++; end
        push_byte(1'b1, 8'hA5);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        while (en_rises < start + 2 && n < 200) begin @(negedge clk); n++; end
        check("abort_reached_en_l", LCD_EN, 1);
        @(posedge clk); #3;
        abort = 1'b1;
        rst = 1'b0;
        #1;
        check("abort_en_low", LCD_EN, 0);
        check("abort_busy_low", busy, 0);
        check("abort_data_cleared", LCD_DATA, 0);
        @(negedge clk);
        do_reset();
        check("abort_last_grant", last_grant, 1);
        send(0, 1'b1, 8'h3C, blen);
        check("busy_after_abort", blen, SHORT_BUSY);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
